// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch controller.
// Holds the data widths, the default fetch reset address, the fetch FSM state
// enum and the prefetch buffer entry layout {pc, instr}.
package ifetch_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned ADDR_W  = 16;

  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 16'h0000;

  // StIdle: no request, StReq: request outstanding,
  // StDrop: request outstanding whose data must be thrown away.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StDrop = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch buffer: DEPTH entries of {pc, instr}, with a registered head.
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   flush              drop all entries (takes priority over push/pop)
//   push, wdata        write one entry (caller guarantees space)
//   pop                remove the head entry (ignored when empty)
//   count              number of stored entries
//   head_valid, head   registered view of the oldest entry
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    push,
  input  fetch_entry_t            wdata,
  input  logic                    pop,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    head_valid,
  output fetch_entry_t            head
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            head_valid_q;
  fetch_entry_t    head_q, head_d;
  logic            do_pop;

  assign do_pop = pop && (count_q != '0);

  always_comb begin
    rptr_d  = rptr_q + PtrW'(do_pop);
    count_d = count_q + CntW'(push) - CntW'(do_pop);
    // The next head is either already stored or is the entry being written now.
    if (push && (wptr_q == rptr_d)) begin
      head_d = wdata;
    end else begin
      head_d = mem_q[rptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      head_valid_q <= 1'b0;
      head_q       <= '0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + PtrW'(1);
      end
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      head_valid_q <= (count_d != '0);
      head_q       <= (count_d != '0) ? head_d : '0;
    end
  end

  assign count      = count_q;
  assign head_valid = head_valid_q;
  assign head       = head_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: issues single outstanding reads to instruction
// memory, buffers returned words with their addresses and hands them to decode.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   pc_in, redirect            redirect target and strobe (flush + refetch)
//   mem_req, mem_addr          registered memory read request
//   mem_ack, mem_rdata         read completion and data
//   instr_valid/out/pc         head instruction presented to decode
//   instr_ready                decode consumes the head when instr_valid is high
// Build option: define IFETCH_BYPASS_EN to present acked data combinationally
// when the buffer is empty (otherwise all outputs are registered).
module imem_fetch_ctrl
  import ifetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned       DEPTH    = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic               redirect,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready
);

  localparam int unsigned     CntW     = $clog2(DEPTH) + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_inc;
  logic              mem_req_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [CntW-1:0]   count, count_after;
  logic              head_valid;
  fetch_entry_t      head, push_entry;
  logic              ack_req, push, pop, bypass_take;

  assign fetch_pc_inc = fetch_pc_q + ADDR_W'(1);
  assign ack_req      = (state_q == StReq) && mem_ack && !redirect;
  assign push_entry   = '{pc: fetch_pc_q, instr: mem_rdata};

`ifdef IFETCH_BYPASS_EN
  logic bypass_show;
  assign bypass_show = ack_req && (count == '0) && !reset;
  assign bypass_take = bypass_show && instr_ready;

  always_comb begin
    if (bypass_show) begin
      instr_valid = 1'b1;
      instr_out   = mem_rdata;
      instr_pc    = fetch_pc_q;
    end else begin
      instr_valid = head_valid;
      instr_out   = head.instr;
      instr_pc    = head.pc;
    end
  end
`else
  assign bypass_take = 1'b0;
  assign instr_valid = head_valid;
  assign instr_out   = head.instr;
  assign instr_pc    = head.pc;
`endif

  assign push = ack_req && !bypass_take;
  assign pop  = head_valid && instr_ready && !redirect;

  // Occupancy once this cycle's push/pop land; a new request reserves a slot
  // against this so the acked word always has room.
  assign count_after = count + CntW'(push) - CntW'(pop);

  ifetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (push),
    .wdata     (push_entry),
    .pop       (pop),
    .count     (count),
    .head_valid(head_valid),
    .head      (head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
    end else if (redirect) begin
      fetch_pc_q <= pc_in;
      unique case (state_q)
        StReq, StDrop: begin
          if (mem_ack) begin
            state_q   <= StIdle;
            mem_req_q <= 1'b0;
          end else begin
            // Request stays on the bus until acked; its data is dropped.
            state_q <= StDrop;
          end
        end
        default: state_q <= StIdle;
      endcase
    end else begin
      unique case (state_q)
        StIdle: begin
          if (count < DepthCnt) begin
            state_q    <= StReq;
            mem_req_q  <= 1'b1;
            mem_addr_q <= fetch_pc_q;
          end
        end
        StReq: begin
          if (mem_ack) begin
            fetch_pc_q <= fetch_pc_inc;
            if (count_after < DepthCnt) begin
              mem_addr_q <= fetch_pc_inc;
            end else begin
              state_q   <= StIdle;
              mem_req_q <= 1'b0;
            end
          end
        end
        StDrop: begin
          if (mem_ack) begin
            if (count < DepthCnt) begin
              state_q    <= StReq;
              mem_addr_q <= fetch_pc_q;
            end else begin
              state_q   <= StIdle;
              mem_req_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q   <= StIdle;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: a memory responder with programmable latency
// feeds a scoreboard of {pc, instr}; decode-side consumption pops and compares.
module tb_imem_fetch_ctrl;

  localparam int unsigned DEPTH    = 2;
  localparam logic [15:0] RESET_PC = 16'h0000;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } sb_entry_t;

  logic        clk = 1'b0;
  logic        reset, redirect, mem_req, mem_ack, instr_valid, instr_ready;
  logic [15:0] pc_in, mem_addr, mem_rdata, instr_out, instr_pc;

  always #5 clk = ~clk;

  imem_fetch_ctrl #(
    .RESET_PC(RESET_PC),
    .DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pc_in      (pc_in),
    .redirect   (redirect),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .instr_valid(instr_valid),
    .instr_out  (instr_out),
    .instr_pc   (instr_pc),
    .instr_ready(instr_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  sb_entry_t   sb_q[$];
  logic [15:0] seen_q[$];

  // Memory model and stimulus controls.
  bit          busy = 0, dropping = 0;
  int          cnt = 0, lat = 1;
  logic [15:0] req_addr = '0, exp_addr = RESET_PC;
  bit          rst_req = 1, redir_req = 0, ready_drv = 1, inject_ack = 0;
  logic [15:0] redir_pc = '0;
  bit          roa = 0;
  logic [15:0] roa_pc = '0;
  bit          lat_probe = 0, probe_next = 0;
  int          probe_hits = 0;
  logic [15:0] probe_data = '0, probe_pc = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    bit        pushed, was_empty, injected;
    sb_entry_t e;
    pushed   = 0;
    injected = 0;
    @(posedge clk);
    #1;
    reset       = rst_req;
    redirect    = redir_req;
    if (redir_req) pc_in = redir_pc;
    instr_ready = ready_drv;
    mem_ack     = 1'b0;
    if (inject_ack) begin
      mem_ack    = 1'b1;
      mem_rdata  = 16'hDEAD;
      inject_ack = 0;
      injected   = 1;
    end else begin
      if (busy) begin
        check_eq("req_held", mem_req, 1);
        check_eq("addr_stable", mem_addr, req_addr);
      end else if (mem_req) begin
        check_eq("req_addr", mem_addr, exp_addr);
        busy     = 1;
        cnt      = lat;
        req_addr = mem_addr;
      end
      if (busy) begin
        if (cnt == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = req_addr ^ 16'hA55A;
          busy      = 0;
        end else begin
          cnt--;
        end
      end
    end
    if (roa && mem_ack) begin
      redirect = 1'b1;
      pc_in    = roa_pc;
      roa      = 0;
    end
    was_empty = (sb_q.size() == 0);
    if (reset) begin
      sb_q.delete();
      seen_q.delete();
      busy     = 0;
      dropping = 0;
      exp_addr = RESET_PC;
    end else if (redirect) begin
      sb_q.delete();
      seen_q.delete();
      dropping = busy;
      exp_addr = pc_in;
    end else if (mem_ack && !injected) begin
      if (dropping) begin
        dropping = 0;
      end else begin
        sb_q.push_back('{pc: req_addr, instr: mem_rdata});
        exp_addr = req_addr + 16'd1;
        pushed   = 1;
      end
    end
    #1;
    if (probe_next) begin
      check_eq("lat_next_valid", instr_valid, 1);
      check_eq("lat_next_out", instr_out, probe_data);
      check_eq("lat_next_pc", instr_pc, probe_pc);
      probe_next = 0;
      probe_hits++;
    end
    if (lat_probe && pushed && was_empty) begin
`ifdef IFETCH_BYPASS_EN
      check_eq("bypass_valid", instr_valid, 1);
      check_eq("bypass_out", instr_out, 16'hA5A5);
      check_eq("bypass_pc", instr_pc, 16'h00FF);
`else
      check_eq("ack_cycle_valid", instr_valid, 0);
`endif
      lat_probe  = 0;
      probe_next = 1;
      probe_data = mem_rdata;
      probe_pc   = req_addr;
    end
    if (!reset && !redirect && instr_valid && instr_ready) begin
      check_eq("sb_nonempty", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check_eq("instr_pc", instr_pc, e.pc);
        check_eq("instr_out", instr_out, e.instr);
        seen_q.push_back(instr_pc);
      end
    end
    redir_req = 0;
  endtask

  task automatic wait_seen(input int n, input string tag);
    for (int i = 0; i < 400 && seen_q.size() < n; i++) tick();
    check_eq(tag, seen_q.size() >= n, 1);
  endtask

  initial begin
    reset       = 1'b1;
    redirect    = 1'b0;
    pc_in       = '0;
    mem_ack     = 1'b0;
    mem_rdata   = '0;
    instr_ready = 1'b0;

    // Reset state.
    repeat (3) tick();
    check_eq("rst_mem_req", mem_req, 0);
    check_eq("rst_mem_addr", mem_addr, RESET_PC);
    check_eq("rst_instr_valid", instr_valid, 0);
    check_eq("rst_instr_out", instr_out, 0);
    check_eq("rst_instr_pc", instr_pc, 0);
    rst_req = 0;
    tick();
    check_eq("release_req_low", mem_req, 0);
    tick();
    check_eq("first_req", mem_req, 1);
    check_eq("first_addr", mem_addr, RESET_PC);

    // Sequential fetch, ack one cycle after each request.
    wait_seen(6, "seq_timeout");
    for (int i = 0; i < 6; i++) begin
      if (i < seen_q.size()) check_eq("seq_pc", seen_q[i], i);
    end

    // Decode stalled: buffer fills to DEPTH and fetching stops.
    ready_drv = 0;
    lat       = 0;
    repeat (12) tick();
    check_eq("stall_count", sb_q.size(), DEPTH);
    check_eq("stall_req_low", mem_req, 0);
    check_eq("stall_valid", instr_valid, 1);
    ready_drv = 1;
    wait_seen(seen_q.size() + 8, "resume_timeout");
    for (int k = 1; k < seen_q.size(); k++) begin
      check_eq("seq_contig", seen_q[k], seen_q[k-1] + 16'd1);
    end

    // Redirect while a request is pending; its data must be dropped.
    lat       = 3;
    redir_pc  = 16'h0005;
    redir_req = 1;
    tick();
    for (int i = 0; i < 100 && !(busy && req_addr == 16'h0005); i++) tick();
    check_eq("pending5_timeout", busy && (req_addr == 16'h0005), 1);
    redir_pc  = 16'h0040;
    redir_req = 1;
    tick();
    wait_seen(2, "drop_timeout");
    if (seen_q.size() >= 2) begin
      check_eq("drop_first_pc", seen_q[0], 16'h0040);
      check_eq("drop_second_pc", seen_q[1], 16'h0041);
    end

    // Redirect coincident with mem_ack.
    lat    = 1;
    roa_pc = 16'h1234;
    roa    = 1;
    for (int i = 0; i < 100 && roa; i++) tick();
    check_eq("roa_timeout", roa, 0);
    wait_seen(2, "roa_seen_timeout");
    if (seen_q.size() >= 2) begin
      check_eq("roa_first_pc", seen_q[0], 16'h1234);
      check_eq("roa_second_pc", seen_q[1], 16'h1235);
    end

    // Address wrap.
    lat       = 0;
    redir_pc  = 16'hFFFF;
    redir_req = 1;
    tick();
    wait_seen(3, "wrap_timeout");
    if (seen_q.size() >= 3) begin
      check_eq("wrap_pc0", seen_q[0], 16'hFFFF);
      check_eq("wrap_pc1", seen_q[1], 16'h0000);
      check_eq("wrap_pc2", seen_q[2], 16'h0001);
    end

    // Ack into an empty buffer: latency / bypass presentation.
    ready_drv = 0;
    lat       = 2;
    redir_pc  = 16'h00FF;
    redir_req = 1;
    lat_probe = 1;
    tick();
    for (int i = 0; i < 50 && probe_hits == 0; i++) tick();
    check_eq("probe_timeout", probe_hits, 1);
    check_eq("probe_out_const", probe_data, 16'hA5A5);
    ready_drv = 1;
    repeat (4) tick();

    // Reset with redirect mid-request, then a stray ack right after reset.
    lat = 3;
    for (int i = 0; i < 50 && !busy; i++) tick();
    check_eq("busy_timeout", busy, 1);
    rst_req   = 1;
    redir_req = 1;
    redir_pc  = 16'h0777;
    tick();
    rst_req    = 0;
    inject_ack = 1;
    tick();
    check_eq("post_rst_valid", instr_valid, 0);
    check_eq("post_rst_req", mem_req, 0);
    wait_seen(2, "post_rst_timeout");
    if (seen_q.size() >= 2) begin
      check_eq("post_rst_pc0", seen_q[0], RESET_PC);
      check_eq("post_rst_pc1", seen_q[1], RESET_PC + 16'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 Parameter: RESET_PC, 16'h0000, fetch address loaded on reset.
REQ-002 Parameter: DEPTH, 2, prefetch buffer entries (power of two, 2..8).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: pc_in  input  16  branch/redirect target, taken from the PC manager's pc_out.
REQ-006 Port: redirect  input  1  pc_in valid this cycle; flush and refetch from pc_in.
REQ-007 Port: mem_req  output  1  instruction memory read request, registered.
REQ-008 Port: mem_addr  output  16  word address of request, registered.
REQ-009 Port: mem_ack  input  1  mem_rdata valid this cycle; completes the outstanding request.
REQ-010 Port: mem_rdata  input  16  instruction word returned by memory.
REQ-011 Port: instr_valid  output  1  instr_out/instr_pc hold a valid instruction.
REQ-012 Port: instr_out  output  16  instruction at buffer head.
REQ-013 Port: instr_pc  output  16  address of instr_out (feeds link_pc / relative-branch base).
REQ-014 Port: instr_ready  input  1  decode consumes head when instr_valid is also high.

Function
REQ-015 At most one memory request SHALL be outstanding; mem_req and mem_addr SHALL stay stable from assertion until the mem_ack cycle.
REQ-016 FSM states SHALL be IDLE (no request), REQ (request outstanding), DROP (outstanding request whose data is to be discarded).
REQ-017 IDLE->REQ when buffer count + 0 < DEPTH and no redirect; REQ->IDLE on mem_ack; REQ->REQ on mem_ack if space remains after the push (back-to-back issue, no bubble).
REQ-018 On mem_ack in REQ, {fetch_pc, mem_rdata} SHALL be pushed into the buffer and fetch_pc incremented by 1, wrapping 16'hFFFF->16'h0000.
REQ-019 Pop SHALL occur when instr_valid && instr_ready; push and pop in the same cycle SHALL leave count unchanged.
REQ-020 Request issue SHALL reserve a buffer slot, so a push never occurs when full and no data is ever dropped except by redirect.
REQ-021 Redirect SHALL have priority over push, pop and issue: buffer cleared, fetch_pc <= pc_in, instr_valid low from the next cycle.
REQ-022 Redirect in REQ without mem_ack SHALL go to DROP; in DROP, mem_ack data SHALL be discarded and the next request SHALL use the redirect address in the following cycle.
REQ-023 Redirect coincident with mem_ack SHALL discard that data and go to IDLE (request to pc_in issued next cycle).
REQ-024 Redirect in DROP SHALL update fetch_pc and remain in DROP.
REQ-025 Default path latency: mem_ack in cycle N -> instr_valid in cycle N+1 when buffer was empty.

Reset
REQ-026 Reset SHALL set fetch_pc=RESET_PC, state=IDLE, buffer empty, mem_req=0, mem_addr=RESET_PC, instr_valid=0, instr_out=0, instr_pc=0.
REQ-027 Reset mid-request SHALL abandon the request; a mem_ack arriving in the cycle after reset SHALL be ignored.
REQ-028 Reset SHALL override redirect in the same cycle.

Configuration
REQ-029 Macro IFETCH_BYPASS_EN: when defined, with buffer empty and mem_ack in REQ, instr_out/instr_pc/instr_valid SHALL present mem_rdata combinationally in the ack cycle; if instr_ready is also high the entry is not pushed.
REQ-030 Without IFETCH_BYPASS_EN all outputs SHALL be registered and REQ-025 latency applies.

Structure
REQ-031 Package ifetch_pkg SHALL hold the FSM state enum, INSTR_W=16, ADDR_W=16 and the default RESET_PC.
REQ-032 The buffer SHALL be a sub-module ifetch_fifo (DEPTH x 32-bit {pc, instr}, push/pop/flush, count, registered head).

Verification
REQ-033 Reset then mem_ack 1 cycle after each request, instr_ready=1 -> instr_pc sequence 0,1,2,...; mem_req first asserted cycle after reset release.
REQ-034 instr_ready=0, acks immediate -> exactly DEPTH pushes, mem_req stays low, count=DEPTH; ready=1 -> fetch resumes, no word lost or duplicated.
REQ-035 Redirect pc_in=16'h0040 while request to 16'h0005 pending, ack 3 cycles later -> that data discarded, next mem_addr=16'h0040, first instr_pc=16'h0040.
REQ-036 Redirect coincident with mem_ack, pc_in=16'h1234 -> acked word never appears; next instr_pc=16'h1234.
REQ-037 Redirect pc_in=16'hFFFF -> instr_pc sequence 16'hFFFF, 16'h0000, 16'h0001.
REQ-038 With IFETCH_BYPASS_EN, empty buffer, mem_ack with rdata=16'hA5A5 -> instr_valid=1, instr_out=16'hA5A5 in the same cycle.
